// File: rtl/efuse_cfg_loader.sv
// Boot-time Wishbone read master: fetches a header-checked configuration image
// from eFuse and shifts it MSB first into the FPGA configuration chain.
module efuse_cfg_loader #(
  parameter int unsigned CFG_BYTES = 256,
  parameter logic [11:0] BASE_ADDR = 12'h000,
  parameter logic [7:0]  MAGIC     = 8'hA5,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic        wbm_sel_o,
  output logic [11:0] wbm_adr_o,
  input  logic [7:0]  wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        cfg_en_o,
  output logic        cfg_data_o
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] HDR_RD  = 3'd1;
  localparam logic [2:0] HDR_CHK = 3'd2;
  localparam logic [2:0] DAT_RD  = 3'd3;
  localparam logic [2:0] SHIFT   = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;
  localparam logic [2:0] ERR     = 3'd6;

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [2:0]    state_q, state_d;
  logic [12:0]   idx_q, idx_d;
  logic [11:0]   adr_q, adr_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [2:0]    bit_q, bit_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          cyc_q, cyc_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic [12:0]   idx_inc;

  assign idx_inc = idx_q + 13'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    adr_d   = adr_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    tcnt_d  = tcnt_q;
    cyc_d   = cyc_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          code_d  = 2'd0;
          idx_d   = '0;
          adr_d   = BASE_ADDR;
          cyc_d   = 1'b1;
          tcnt_d  = '0;
          busy_d  = 1'b1;
          state_d = HDR_RD;
        end
      end
      HDR_RD, DAT_RD: begin
        // Ack wins over a timeout expiring in the same cycle.
        if (wbm_ack_i) begin
          shreg_d = wbm_dat_i;
          cyc_d   = 1'b0;
          bit_d   = '0;
          state_d = (state_q == HDR_RD) ? HDR_CHK : SHIFT;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          cyc_d   = 1'b0;
          code_d  = 2'd2;
          state_d = ERR;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      HDR_CHK: begin
        if (shreg_q == MAGIC) begin
          idx_d   = 13'd1;
          adr_d   = BASE_ADDR + 12'd1;
          cyc_d   = 1'b1;
          tcnt_d  = '0;
          state_d = DAT_RD;
        end else begin
          code_d  = 2'd1;
          state_d = ERR;
        end
      end
      SHIFT: begin
        shreg_d = {shreg_q[6:0], 1'b0};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          if (idx_q == 13'(CFG_BYTES)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_inc;
            adr_d   = BASE_ADDR + idx_inc[11:0];
            cyc_d   = 1'b1;
            tcnt_d  = '0;
            state_d = DAT_RD;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      ERR: begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      adr_q   <= '0;
      shreg_q <= '0;
      bit_q   <= '0;
      tcnt_q  <= '0;
      cyc_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      adr_q   <= adr_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      tcnt_q  <= tcnt_d;
      cyc_q   <= cyc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_code_o = code_q;
  assign wbm_cyc_o  = cyc_q;
  assign wbm_stb_o  = cyc_q;
  assign wbm_sel_o  = cyc_q;
  assign wbm_we_o   = 1'b0;
  assign wbm_adr_o  = adr_q;
  assign cfg_en_o   = (state_q == SHIFT);
  assign cfg_data_o = cfg_en_o & shreg_q[7];

endmodule

// File: tb/tb_efuse_cfg_loader.sv
// Scoreboard bench for efuse_cfg_loader: three parameterisations share one
// eFuse slave model; expected addresses and chain bits are queued up front.
module tb_efuse_cfg_loader;

  logic        clk;
  logic        rst;
  logic        start [3];
  logic        busy  [3];
  logic        done  [3];
  logic        err   [3];
  logic [1:0]  ecode [3];
  logic        cyc   [3];
  logic        stb   [3];
  logic        we    [3];
  logic        sel   [3];
  logic [11:0] adr   [3];
  logic [7:0]  dat   [3];
  logic        ack   [3];
  logic        en    [3];
  logic        data  [3];

  logic [7:0]  mem [4096];
  int          scnt [3];
  int          sdly [3];
  int          dmax;
  bit          noack;

  logic [11:0] exp_adr  [$];
  logic        exp_bits [$];

  int n_chk, n_fail;
  int cur;
  int rd_cnt, en_cnt, stb_cnt, done_rise;
  logic done_prev;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    efuse_cfg_loader #(
      .CFG_BYTES(g == 0 ? 2 : (g == 1 ? 256 : 1)),
      .BASE_ADDR(g == 2 ? 12'hFFF : 12'h000),
      .MAGIC    (8'hA5),
      .TIMEOUT  (64)
    ) u_dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .start_i   (start[g]),
      .busy_o    (busy[g]),
      .done_o    (done[g]),
      .err_o     (err[g]),
      .err_code_o(ecode[g]),
      .wbm_cyc_o (cyc[g]),
      .wbm_stb_o (stb[g]),
      .wbm_we_o  (we[g]),
      .wbm_sel_o (sel[g]),
      .wbm_adr_o (adr[g]),
      .wbm_dat_i (dat[g]),
      .wbm_ack_i (ack[g]),
      .cfg_en_o  (en[g]),
      .cfg_data_o(data[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // eFuse slave: ack after a random 1..dmax cycles of strobe, one-cycle ack pulse.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int g = 0; g < 3; g++) begin
        ack[g] <= 1'b0;
        dat[g] <= 8'h00;
        scnt[g] = 0;
        sdly[g] = 1;
      end
    end else begin
      for (int g = 0; g < 3; g++) begin
        ack[g] <= 1'b0;
        if (stb[g] && !ack[g]) begin
          scnt[g] = scnt[g] + 1;
          if (scnt[g] == 1) sdly[g] = $urandom_range(dmax, 1);
          if (!noack && scnt[g] >= sdly[g]) begin
            ack[g] <= 1'b1;
            dat[g] <= mem[adr[g]];
            scnt[g] = 0;
          end
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs(input int g);
    return {9'd0, busy[g], done[g], err[g], ecode[g], cyc[g], stb[g], we[g], sel[g],
            adr[g], en[g], data[g]};
  endfunction

  task automatic step();
    @(negedge clk);
    if (cyc[cur]) begin
      check_eq("we", 32'(we[cur]), 32'd0);
      check_eq("sel", 32'(sel[cur]), 32'd1);
    end
    if (stb[cur]) stb_cnt++;
    if (stb[cur] && ack[cur]) begin
      rd_cnt++;
      if (exp_adr.size() > 0) check_eq("adr", 32'(adr[cur]), 32'(exp_adr.pop_front()));
    end
    if (en[cur]) begin
      en_cnt++;
      if (exp_bits.size() > 0) check_eq("cfg_bit", 32'(data[cur]), 32'(exp_bits.pop_front()));
    end else begin
      check_eq("cfg_idle", 32'(data[cur]), 32'd0);
    end
    if (done[cur] && !done_prev) done_rise++;
    done_prev = done[cur];
  endtask

  task automatic clr(input int g);
    cur = g;
    exp_adr.delete();
    exp_bits.delete();
    rd_cnt = 0; en_cnt = 0; stb_cnt = 0; done_rise = 0;
    done_prev = done[g];
  endtask

  task automatic push_image(input logic [11:0] base, input int n);
    logic [7:0] b;
    for (int i = 0; i <= n; i++) exp_adr.push_back(12'(base + 12'(i)));
    for (int i = 1; i <= n; i++) begin
      b = mem[12'(base + 12'(i))];
      for (int k = 7; k >= 0; k--) exp_bits.push_back(b[k]);
    end
  endtask

  task automatic run_load(input int g, input int budget, input int restart_at, output int n);
    start[g] = 1'b1;
    step();
    start[g] = 1'b0;
    n = 1;
    check_eq("start_clr", 32'({done[g], err[g], ecode[g]}), 32'd0);
    while (!(done[g] || err[g]) && n < budget) begin
      if (n == restart_at) start[g] = 1'b1;
      step();
      start[g] = 1'b0;
      n++;
    end
    check_eq("finished", 32'(done[g] | err[g]), 32'd1);
  endtask

  initial begin
    int n;
    logic [15:0] img;
    n_chk = 0; n_fail = 0;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    dmax = 1; noack = 1'b0;
    cur = 0; done_prev = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    for (int g = 0; g < 3; g++) check_eq("reset_outs", outs(g), 32'd0);
    rst = 1'b0;
    step();

    // Two-byte image, one-cycle ack
    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'h81;
    clr(0);
    for (int i = 0; i <= 2; i++) exp_adr.push_back(12'(i));
    img = 16'h3C81;
    for (int k = 15; k >= 0; k--) exp_bits.push_back(img[k]);
    run_load(0, 200, 0, n);
    check_eq("t1_cycles", 32'(n), 32'd25);
    check_eq("t1_done", 32'(done[0]), 32'd1);
    check_eq("t1_err", 32'(err[0]), 32'd0);
    check_eq("t1_busy", 32'(busy[0]), 32'd0);
    check_eq("t1_bits", 32'(en_cnt), 32'd16);
    check_eq("t1_reads", 32'(rd_cnt), 32'd3);
    repeat (3) step();

    // Bad header
    mem[0] = 8'h5A;
    clr(0);
    exp_adr.push_back(12'h000);
    run_load(0, 200, 0, n);
    repeat (5) step();
    check_eq("t2_reads", 32'(rd_cnt), 32'd1);
    check_eq("t2_err", 32'(err[0]), 32'd1);
    check_eq("t2_code", 32'(ecode[0]), 32'd1);
    check_eq("t2_done", 32'(done[0]), 32'd0);
    check_eq("t2_en", 32'(en_cnt), 32'd0);

    // Slave never acks
    noack = 1'b1;
    clr(0);
    run_load(0, 300, 0, n);
    check_eq("t3_stb_cycles", 32'(stb_cnt), 32'd64);
    check_eq("t3_cyc", 32'(cyc[0]), 32'd0);
    check_eq("t3_code", 32'(ecode[0]), 32'd2);
    check_eq("t3_busy", 32'(busy[0]), 32'd0);
    check_eq("t3_err", 32'(err[0]), 32'd1);
    check_eq("t3_reads", 32'(rd_cnt), 32'd0);
    noack = 1'b0;
    repeat (3) step();

    // Full 256-byte image with random ack latency
    mem[0] = 8'hA5;
    dmax = 10;
    clr(1);
    push_image(12'h000, 256);
    run_load(1, 8000, 0, n);
    check_eq("t4_done", 32'(done[1]), 32'd1);
    check_eq("t4_err", 32'(err[1]), 32'd0);
    check_eq("t4_bits", 32'(en_cnt), 32'd2048);
    check_eq("t4_reads", 32'(rd_cnt), 32'd257);
    check_eq("t4_adr_left", 32'(exp_adr.size()), 32'd0);
    repeat (3) step();

    // Reset during the third payload shift, then reload
    dmax = 1;
    clr(1);
    push_image(12'h000, 256);
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    n = 1;
    while (en_cnt < 19 && n < 500) begin
      step();
      n++;
    end
    check_eq("t5_reached_shift", 32'(en[1]), 32'd1);
    #2 rst = 1'b1;
    #1 check_eq("t5_rst_outs", outs(1), 32'd0);
    clr(1);
    step();
    rst = 1'b0;
    step();
    dmax = 4;
    clr(1);
    push_image(12'h000, 256);
    run_load(1, 8000, 0, n);
    check_eq("t5_done", 32'(done[1]), 32'd1);
    check_eq("t5_bits", 32'(en_cnt), 32'd2048);
    check_eq("t5_reads", 32'(rd_cnt), 32'd257);
    repeat (3) step();

    // Address wrap and ignored start while busy
    dmax = 1;
    mem[12'hFFF] = 8'hA5;
    mem[12'h000] = 8'h5B;
    clr(2);
    push_image(12'hFFF, 1);
    run_load(2, 200, 4, n);
    repeat (30) step();
    check_eq("t6_done", 32'(done[2]), 32'd1);
    check_eq("t6_done_rise", 32'(done_rise), 32'd1);
    check_eq("t6_reads", 32'(rd_cnt), 32'd2);
    check_eq("t6_bits", 32'(en_cnt), 32'd8);
    check_eq("t6_adr_left", 32'(exp_adr.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
